// File: rtl/idt_pkg.sv
// Shared state encoding, gate-type and fault constants for the IDT gate fetch path.
// Pure declarations: no latency, no flow control.
package idt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOW_ADDR,
      ST_LOW_DATA,
      ST_HIGH_ADDR,
      ST_HIGH_DATA,
      ST_RESPOND
   } state_t;

   localparam logic [3:0] GATE_TASK   = 4'h5;
   localparam logic [3:0] GATE_INT16  = 4'h6;
   localparam logic [3:0] GATE_TRAP16 = 4'h7;
   localparam logic [3:0] GATE_INT32  = 4'hE;
   localparam logic [3:0] GATE_TRAP32 = 4'hF;

   localparam logic [7:0] FAULT_GP = 8'd13;
   localparam logic [7:0] FAULT_NP = 8'd11;

   localparam int ERR_EXT_BIT = 0;
   localparam int ERR_IDT_BIT = 1;

   function automatic logic gate_type_known(input logic [3:0] gate_type);
      return gate_type inside {GATE_TASK, GATE_INT16, GATE_TRAP16, GATE_INT32, GATE_TRAP32};
   endfunction

   // Selector-format error code pointing at the IDT entry: TI=0, IDT=1, EXT from the event.
   function automatic logic [15:0] idt_error_code(input logic [7:0] vector, input logic external);
      logic [15:0] code;
      code = {5'b0, vector, 3'b000};
      code[ERR_IDT_BIT] = 1'b1;
      code[ERR_EXT_BIT] = external;
      return code;
   endfunction

endpackage

// File: rtl/idt_gate_decoder.sv
// Combinational split of an 8-byte IDT gate into fields; zero latency, no flow control.
// With IDT_GATE_CHECK_EN defined it also flags bad type/S (#GP) and not-present (#NP).
module idt_gate_decoder (
   input  logic [31:0] low_dword,
   input  logic [31:0] high_dword,
   output logic [15:0] selector,
   output logic [31:0] offset,
   output logic [3:0]  gate_type,
   output logic [1:0]  dpl,
   output logic        present,
   output logic        fault,
   output logic [7:0]  fault_vector
);
   import idt_pkg::*;

   assign selector  = low_dword[31:16];
   assign offset    = {high_dword[31:16], low_dword[15:0]};
   assign present   = high_dword[15];
   assign dpl       = high_dword[14:13];
   assign gate_type = high_dword[11:8];

`ifdef IDT_GATE_CHECK_EN
   // A malformed descriptor outranks a missing one.
   always_comb begin
      fault        = 1'b0;
      fault_vector = '0;
      if (high_dword[12] || !gate_type_known(gate_type)) begin
         fault        = 1'b1;
         fault_vector = FAULT_GP;
      end else if (!present) begin
         fault        = 1'b1;
         fault_vector = FAULT_NP;
      end
   end

   logic unused_bits;
   assign unused_bits = ^high_dword[7:0];
`else
   assign fault        = 1'b0;
   assign fault_vector = '0;

   logic unused_bits;
   assign unused_bits = ^{high_dword[12], high_dword[7:0]};
`endif

endmodule

// File: rtl/interrupt_gate_fetch.sv
// IDT gate fetch: limit check, two dword reads, decoded gate or fault; 1 cycle on limit fault,
// 5+ cycles otherwise; stalls on memory ready/valid, holds the result until gate_ready. Macro: IDT_GATE_CHECK_EN.
module interrupt_gate_fetch (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] IDTR_limit,
   input  logic [31:0] IDTR_base,
   input  logic        request_valid,
   output logic        request_ready,
   input  logic [7:0]  request_vector,
   input  logic        request_external,
   output logic        memory_read_request,
   output logic [31:0] memory_read_address,
   input  logic        memory_read_ready,
   input  logic        memory_read_valid,
   input  logic [31:0] memory_read_data,
   output logic        gate_valid,
   input  logic        gate_ready,
   output logic        gate_fault,
   output logic [7:0]  gate_fault_vector,
   output logic [15:0] gate_error_code,
   output logic [15:0] gate_selector,
   output logic [31:0] gate_offset,
   output logic [3:0]  gate_type,
   output logic [1:0]  gate_dpl,
   output logic        gate_present
);
   import idt_pkg::*;

   state_t      state, state_next;
   logic [31:0] address;
   logic [31:0] low_dword, high_dword;
   logic [7:0]  vector;
   logic        external;
   logic        limit_fault;
   logic        accept, limit_exceeded;

   logic [15:0] dec_selector;
   logic [31:0] dec_offset;
   logic [3:0]  dec_type;
   logic [1:0]  dec_dpl;
   logic        dec_present, dec_fault;
   logic [7:0]  dec_fault_vector;

   assign accept         = (state == ST_IDLE) && request_valid;
   assign limit_exceeded = {5'b0, request_vector, 3'b111} > IDTR_limit;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:      if (request_valid)     state_next = limit_exceeded ? ST_RESPOND : ST_LOW_ADDR;
         ST_LOW_ADDR:  if (memory_read_ready) state_next = ST_LOW_DATA;
         ST_LOW_DATA:  if (memory_read_valid) state_next = ST_HIGH_ADDR;
         ST_HIGH_ADDR: if (memory_read_ready) state_next = ST_HIGH_DATA;
         ST_HIGH_DATA: if (memory_read_valid) state_next = ST_RESPOND;
         ST_RESPOND:   if (gate_ready)        state_next = ST_IDLE;
         default:                             state_next = ST_IDLE;
      endcase
   end

   // The IDTR is only consulted at accept: base is folded into the address register
   // and the limit verdict is captured, so later IDTR writes cannot disturb a fetch.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         address     <= '0;
         low_dword   <= '0;
         high_dword  <= '0;
         vector      <= '0;
         external    <= 1'b0;
         limit_fault <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            vector      <= request_vector;
            external    <= request_external;
            limit_fault <= limit_exceeded;
            address     <= IDTR_base + {21'b0, request_vector, 3'b000};
         end
         if (state == ST_LOW_DATA && memory_read_valid) begin
            low_dword <= memory_read_data;
            address   <= address + 32'd4;
         end
         if (state == ST_HIGH_DATA && memory_read_valid)
            high_dword <= memory_read_data;
      end
   end

   idt_gate_decoder u_decoder (
      .low_dword    (low_dword),
      .high_dword   (high_dword),
      .selector     (dec_selector),
      .offset       (dec_offset),
      .gate_type    (dec_type),
      .dpl          (dec_dpl),
      .present      (dec_present),
      .fault        (dec_fault),
      .fault_vector (dec_fault_vector)
   );

   assign request_ready       = (state == ST_IDLE) && !reset;
   assign memory_read_request = (state == ST_LOW_ADDR) || (state == ST_HIGH_ADDR);
   assign memory_read_address = memory_read_request ? address : '0;
   assign gate_valid          = (state == ST_RESPOND);

   // Result fields come only from registers, so they are stable for the whole RESPOND stay.
   always_comb begin
      gate_fault        = 1'b0;
      gate_fault_vector = '0;
      gate_error_code   = '0;
      gate_selector     = '0;
      gate_offset       = '0;
      gate_type         = '0;
      gate_dpl          = '0;
      gate_present      = 1'b0;
      if (gate_valid) begin
         gate_error_code = idt_error_code(vector, external);
         if (limit_fault) begin
            gate_fault        = 1'b1;
            gate_fault_vector = FAULT_GP;
         end else begin
            gate_fault        = dec_fault;
            gate_fault_vector = dec_fault_vector;
            gate_selector     = dec_selector;
            gate_offset       = dec_offset;
            gate_type         = dec_type;
            gate_dpl          = dec_dpl;
            gate_present      = dec_present;
         end
      end
   end

endmodule

// File: doc/interrupt_gate_fetch.md
# interrupt_gate_fetch

Fetches the 8-byte gate descriptor for an interrupt or exception vector from the Interrupt Descriptor Table, using the base and limit held in the IDTR. Sits directly downstream of `interrupt_descriptor_table_register` and upstream of the interrupt/task-switch control sequencer. Performs the IDT limit check and issues two 32-bit memory reads. Returns either a decoded gate or a fault with a 386-format error code.

## Interface
- No parameters.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `IDTR_limit` in 16: current IDT limit from the IDTR.
- `IDTR_base` in 32: current IDT linear base from the IDTR.
- `request_valid` in 1: a vector is offered.
- `request_ready` out 1: the block can accept a vector.
- `request_vector` in 8: vector number.
- `request_external` in 1: the event is external (hardware interrupt or exception); supplies the EXT bit.
- `memory_read_request` out 1: read request.
- `memory_read_address` out 32: dword read address.
- `memory_read_ready` in 1: memory accepts the request this cycle.
- `memory_read_valid` in 1: read data is present.
- `memory_read_data` in 32: read data.
- `gate_valid` out 1: a result (gate or fault) is presented.
- `gate_ready` in 1: the consumer takes the result.
- `gate_fault` out 1: the result is a fault, not a gate.
- `gate_fault_vector` out 8: fault to raise, 13 (#GP) or 11 (#NP).
- `gate_error_code` out 16: `{5'b0, vector, 1'b0, 1'b1, EXT}`, i.e. vector<<3 | IDT bit | EXT.
- `gate_selector` out 16: target selector.
- `gate_offset` out 32: target offset.
- `gate_type` out 4: descriptor type field.
- `gate_dpl` out 2: descriptor DPL.
- `gate_present` out 1: descriptor P bit.

## Operation
- **States:** IDLE, LOW_ADDR, LOW_DATA, HIGH_ADDR, HIGH_DATA, RESPOND.
- **IDLE:** `request_ready`=1. On `request_valid`, latch the vector, EXT, `IDTR_base` and `IDTR_limit`. Later IDTR writes do not affect an in-flight fetch.
- **Limit check (at accept):** `{vector,3'b111}` (11 bits, zero-extended) > `IDTR_limit` → go to RESPOND with a #GP fault. Otherwise go to LOW_ADDR.
- **LOW_ADDR:** `memory_read_request`=1, address = base + `{vector,3'b000}` (mod 2^32). On `memory_read_ready`, go to LOW_DATA.
- **LOW_DATA:** on `memory_read_valid`, capture the low dword and go to HIGH_ADDR.
- **HIGH_ADDR:** same as LOW_ADDR with address low+4 (mod 2^32, wrap allowed), then go to HIGH_DATA.
- **HIGH_DATA:** on `memory_read_valid`, capture the high dword and go to RESPOND.
- **Decode:**
  - selector = low[31:16].
  - offset = {high[31:16], low[15:0]}.
  - P = high[15], DPL = high[14:13], type = high[11:8].
- **RESPOND:** `gate_valid`=1 and all result outputs stay stable until `gate_ready`. Then return to IDLE. There is no combinational ready→valid path.
- **Ignored input:** `memory_read_valid` outside the *_DATA states.
- **Reset values:** `request_ready`=0 during reset and 1 after. All other outputs are 0 (`memory_read_request`, `memory_read_address`, `gate_*`). State is IDLE. Reset in any state aborts the fetch, and a stale memory response arriving later is ignored.

## Timing
- **Limit fault:** accept at T0 → `gate_valid` at T1.
- **Zero-wait memory** (ready the same cycle, data the next):
  - T0 accept.
  - T1 low request.
  - T2 low data.
  - T3 high request.
  - T4 high data.
  - T5 `gate_valid`.
  - Minimum latency 5 cycles. Each memory stall adds one cycle.
- **Back-to-back requests:** a new request can be accepted the cycle after `gate_valid && gate_ready`. Throughput is at most one fetch per 6 cycles.

## Configuration
- **`IDT_GATE_CHECK_EN` defined:**
  - S bit (high[12]) must be 0 and the type must be one of 0x5, 0x6, 0x7, 0xE, 0xF. Otherwise the result is a #GP fault (vector 13).
  - If the type is valid and P=0, the result is a #NP fault (vector 11).
  - Faults carry the same error code as the limit fault.
- **Not defined:** after a passing limit check, the descriptor is returned raw with `gate_fault`=0. The consumer performs the checks. Only the limit check can fault.

## Structure
- **Package `idt_pkg`:**
  - state enum.
  - gate type constants: TASK=5, INT16=6, TRAP16=7, INT32=14, TRAP32=15.
  - fault vectors: GP=13, NP=11.
  - error-code bit positions: EXT=0, IDT=1.
- **Sub-module `idt_gate_decoder`:** combinational. Takes the two dwords and produces the fields plus fault/fault_vector; the type and present checks sit under the macro.

## Test plan
- **Normal 386 interrupt gate:** limit=0x07FF, base=0x0001_0000, vector 0x21, low=0x0008_1234, high=0x5678_8E00, zero-wait memory → addresses 0x0001_0108 then 0x0001_010C; selector 0x0008, offset 0x5678_1234, type 0xE, DPL 0, P 1, result at T5.
- **Limit fault:** limit=0x00FF, vector 0x20, EXT=1 → `gate_valid` at T1, fault vector 13, error code 0x0103, no memory request.
- **Wrap-around:** base=0xFFFF_FFF8, vector 1 → addresses 0x0000_0000 then 0x0000_0004.
- **Not present (macro on):** high=0x0000_0E00 → fault vector 11, error code `{vector,3'b010}`. Bad type 0x1 → fault vector 13. Macro off → raw descriptor, `gate_fault`=0.
- **Stalls and back-pressure:** `memory_read_ready` low 3 cycles and data delayed 2 cycles → request/address held stable; `gate_ready` low 4 cycles → outputs held; an IDTR write mid-fetch does not change the addresses.
- **Reset in HIGH_DATA:** all outputs return to 0 and state to IDLE; a late `memory_read_valid` is ignored; the next request completes normally.
